// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: single-outstanding req/ack fetcher feeding a small
// {pc, instr} prefetch FIFO, with stall hold and branch redirect.
module fetch_prefetch_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int IW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          StallF,
    input  logic          PCSrcE,
    input  logic [AW-1:0] BranchTargetE,
    output logic [AW-1:0] PC,
    output logic [IW-1:0] InstrF,
    output logic          InstrValidF,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata
);

    // state    | meaning
    // REQ_IDLE | no request outstanding
    // REQ_BUSY | request outstanding, response will be pushed
    // REQ_DROP | request outstanding, response belongs to a flushed path
    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_BUSY = 2'd1,
        REQ_DROP = 2'd2
    } req_state_t;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    req_state_t    state;
    req_state_t    state_next;

    logic [AW-1:0] pc_mem    [DEPTH];
    logic [IW-1:0] instr_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] last_pc;
    logic [AW-1:0] addr_q;

    logic          issue;
    logic          push;
    logic          pop;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            REQ_IDLE: begin
                // Only issue when a FIFO slot is free, so the response can never overflow.
                if (!PCSrcE && (count < CW'(DEPTH))) begin
                    issue      = 1'b1;
                    state_next = REQ_BUSY;
                end
            end
            REQ_BUSY: begin
                if (imem_ack) begin
                    state_next = REQ_IDLE;
                end else if (PCSrcE) begin
                    state_next = REQ_DROP;
                end
            end
            REQ_DROP: begin
                if (imem_ack) begin
                    state_next = REQ_IDLE;
                end
            end
            default: state_next = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= REQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign imem_req    = (state != REQ_IDLE);
    assign imem_addr   = addr_q;
    assign InstrValidF = (count != '0);
    assign PC          = InstrValidF ? pc_mem[head] : last_pc;
    assign InstrF      = InstrValidF ? instr_mem[head] : '0;

    assign push = (state == REQ_BUSY) && imem_ack && !PCSrcE;
    assign pop  = InstrValidF && !StallF && !PCSrcE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else if (issue) begin
            addr_q <= fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= '0;
            last_pc  <= '0;
        end else begin
            last_pc <= PC;
            if (PCSrcE) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                fetch_pc <= BranchTargetE;
            end else begin
                if (push) begin
                    tail     <= tail + PW'(1);
                    fetch_pc <= fetch_pc + AW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= imem_addr;
            instr_mem[tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: per-cycle vector table plus
// hand-written stall, redirect, wrap and async-reset sequences.
module tb_fetch_prefetch_unit;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        PCSrcE;
    logic [7:0]  BranchTargetE;
    logic [7:0]  PC;
    logic [15:0] InstrF;
    logic        InstrValidF;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int mem_lat = 0;
    int mem_wait = 0;
    int n_push  = 0;

    logic [7:0]  got_pc    [8];
    logic [15:0] got_instr [8];
    int          n_got;

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic [7:0]  target;
        logic        e_req;
        logic [7:0]  e_addr;
        logic        e_valid;
        logic [7:0]  e_pc;
        logic [15:0] e_instr;
    } vec_t;

    vec_t vecs [14];

    fetch_prefetch_unit #(.DEPTH(4), .AW(8), .IW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .StallF       (StallF),
        .PCSrcE       (PCSrcE),
        .BranchTargetE(BranchTargetE),
        .PC           (PC),
        .InstrF       (InstrF),
        .InstrValidF  (InstrValidF),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ack mem_lat cycles after req is first seen, data = A000 + addr.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            imem_ack   = 1'b0;
            imem_rdata = 16'h0000;
            mem_wait   = 0;
        end else if (imem_ack) begin
            imem_ack = 1'b0;
            mem_wait = 0;
        end else if (imem_req) begin
            if (mem_wait >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = 16'hA000 | {8'h00, imem_addr};
            end else begin
                mem_wait++;
            end
        end
    end

    always @(posedge clk) begin
        if (reset && imem_req && imem_ack) n_push++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int lat);
        reset         = 1'b0;
        StallF        = 1'b0;
        PCSrcE        = 1'b0;
        BranchTargetE = 8'h00;
        mem_lat       = lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Records each head as it is delivered (StallF must be 0 while collecting).
    task automatic collect(input int n);
        int budget;
        budget = 0;
        n_got  = 0;
        while (n_got < n && budget < 80) begin
            if (InstrValidF) begin
                got_pc[n_got]    = PC;
                got_instr[n_got] = InstrF;
                n_got++;
            end
            if (n_got < n) begin
                @(posedge clk);
                #1;
                budget++;
            end
        end
        check("collect_count", n_got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int found;
        logic [7:0] wrap_exp [4];

        // stall pcsrc target | req addr valid pc instr  (state after the edge)
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 16'hA000};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 16'h0000};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h01, 16'hA001};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 8'h00, 16'h0000};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h02, 16'hA002};
        vecs[6]  = '{1'b0, 1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 8'h00, 16'h0000};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h20, 16'hA020};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h21, 1'b1, 8'h20, 16'hA020};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h20, 16'hA020};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 8'h21, 16'hA021};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h22, 16'hA022};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h23, 1'b0, 8'h00, 16'h0000};

        // Reset state
        reset = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; BranchTargetE = 8'h00; mem_lat = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 8'h00);
        check("rst_valid", InstrValidF, 0);
        check("rst_pc", PC, 8'h00);
        check("rst_instr", InstrF, 16'h0000);

        // Table: zero-wait memory from reset release
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 14; i++) begin
            StallF        = vecs[i].stall;
            PCSrcE        = vecs[i].pcsrc;
            BranchTargetE = vecs[i].target;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_req", i), imem_req, vecs[i].e_req);
            if (vecs[i].e_req) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_valid", i), InstrValidF, vecs[i].e_valid);
            if (vecs[i].e_valid) check($sformatf("vec%0d_pc", i), PC, vecs[i].e_pc);
            check($sformatf("vec%0d_instr", i), InstrF, vecs[i].e_instr);
        end
        StallF = 1'b0; PCSrcE = 1'b0;

        // Stall fills the FIFO to DEPTH and then stops fetching
        do_reset(0);
        base = n_push;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (InstrValidF) found = 1;
        end
        check("stall_first_valid", found, 1);
        StallF = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall_pc_hold", PC, 8'h00);
        end
        check("stall_push_count", n_push - base, 4);
        check("stall_req_idle", imem_req, 0);
        StallF = 1'b0;
        collect(5);
        for (int i = 0; i < n_got; i++) begin
            check("stall_order_pc", got_pc[i], i);
            check("stall_order_instr", got_instr[i], 16'hA000 + i);
        end

        // Redirect while addr-05 request is outstanding: response dropped
        do_reset(3);
        found = 0;
        for (int i = 0; i < 150 && !found; i++) begin
            @(posedge clk); #1;
            if (imem_req && imem_addr == 8'h05) found = 1;
        end
        check("disc_req05_seen", found, 1);
        PCSrcE = 1'b1; BranchTargetE = 8'h40;
        @(posedge clk); #1;
        PCSrcE = 1'b0;
        check("disc_flushed", InstrValidF, 0);
        check("disc_req_held", imem_req, 1);
        check("disc_addr_held", imem_addr, 8'h05);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (imem_req && imem_addr != 8'h05) found = 1;
        end
        check("disc_next_req", found, 1);
        check("disc_next_addr", imem_addr, 8'h40);
        collect(1);
        check("disc_first_pc", got_pc[0], 8'h40);
        check("disc_first_instr", got_instr[0], 16'hA040);

        // Redirect in the same cycle as the addr-07 ack: no discard armed
        do_reset(3);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (imem_req && imem_addr == 8'h07) found = 1;
        end
        check("same_req07_seen", found, 1);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk); #1;
            if (imem_ack) found = 1;
        end
        check("same_ack_seen", found, 1);
        PCSrcE = 1'b1; BranchTargetE = 8'h80;
        @(posedge clk); #1;
        PCSrcE = 1'b0;
        check("same_empty", InstrValidF, 0);
        check("same_req_low", imem_req, 0);
        @(posedge clk); #1;
        check("same_next_req", imem_req, 1);
        check("same_next_addr", imem_addr, 8'h80);
        collect(1);
        check("same_first_pc", got_pc[0], 8'h80);
        check("same_first_instr", got_instr[0], 16'hA080);

        // Address wrap after branch to FE
        do_reset(0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (InstrValidF) found = 1;
        end
        check("wrap_first_valid", found, 1);
        PCSrcE = 1'b1; BranchTargetE = 8'hFE;
        @(posedge clk); #1;
        PCSrcE = 1'b0;
        collect(4);
        wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;
        for (int i = 0; i < n_got; i++) begin
            check("wrap_pc", got_pc[i], wrap_exp[i]);
            check("wrap_instr", got_instr[i], 16'hA000 | {8'h00, wrap_exp[i]});
        end

        // Asynchronous reset with 3 entries held and a request outstanding
        do_reset(3);
        StallF = 1'b1;
        base = n_push;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if ((n_push - base) == 3 && imem_req) found = 1;
        end
        check("arst_setup", found, 1);
        check("arst_pre_valid", InstrValidF, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_valid", InstrValidF, 0);
        check("arst_instr", InstrF, 16'h0000);
        check("arst_pc", PC, 8'h00);
        mem_lat = 0;
        StallF  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        collect(2);
        check("arst_restart_pc0", got_pc[0], 8'h00);
        check("arst_restart_pc1", got_pc[1], 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
